// File: rtl/clkdiv_cfg_ctrl.sv
// Divide-ratio change sequencer: round-robin arbitration between two requesters,
// then bypass -> load -> settle before acknowledging. Sole driver of the divider ratio.
module clkdiv_cfg_ctrl #(
   parameter logic [15:0] DIV_RST    = 16'd1,
   parameter int          BYP_CYC    = 4,
   parameter int          SETTLE_CYC = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic [15:0] div0,
   output logic        ack0,
   input  logic        req1,
   input  logic [15:0] div1,
   output logic        ack1,
   output logic [15:0] div_out,
   output logic        busy,
   output logic        gnt_id
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BYPASS,
      S_SETTLE,
      S_DONE
   } state_t;

   state_t      state_q;
   logic [15:0] div_q;
   logic [15:0] tgt_q;
   logic [16:0] cnt_q;
   logic        last_q;
   logic        gnt_q;
   logic        busy_q;
   logic        ack0_q;
   logic        ack1_q;

   logic        any_req_d;
   logic        win_d;
   logic [15:0] raw_d;
   logic [15:0] tgt_d;

   // 17-bit so the largest ratio plus settle time cannot wrap
   function automatic logic [16:0] settle_cnt(input logic [15:0] t);
      return 17'(SETTLE_CYC) + {1'b0, t} - 17'd1;
   endfunction

   always_comb begin
      any_req_d = req0 | req1;
      win_d     = (req0 && req1) ? ~last_q : req1;
      raw_d     = win_d ? div1 : div0;
      tgt_d     = (raw_d == '0) ? 16'd1 : raw_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         div_q   <= DIV_RST;
         tgt_q   <= '0;
         cnt_q   <= '0;
         last_q  <= 1'b1;
         gnt_q   <= 1'b0;
         busy_q  <= 1'b0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
      end else begin
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (any_req_d) begin
                  last_q <= win_d;
                  gnt_q  <= win_d;
                  tgt_q  <= tgt_d;
                  busy_q <= 1'b1;
                  if (tgt_d == div_q) begin
                     state_q <= S_DONE;
                     ack0_q  <= ~win_d;
                     ack1_q  <= win_d;
                  end else if (tgt_d <= 16'd1 || div_q <= 16'd1) begin
                     state_q <= S_SETTLE;
                     div_q   <= tgt_d;
                     cnt_q   <= settle_cnt(tgt_d);
                  end else begin
                     state_q <= S_BYPASS;
                     div_q   <= 16'd1;
                     cnt_q   <= 17'(BYP_CYC - 1);
                  end
               end
            end
            S_BYPASS: begin
               if (cnt_q == '0) begin
                  state_q <= S_SETTLE;
                  div_q   <= tgt_q;
                  cnt_q   <= settle_cnt(tgt_q);
               end else begin
                  cnt_q <= cnt_q - 17'd1;
               end
            end
            S_SETTLE: begin
               if (cnt_q == '0) begin
                  state_q <= S_DONE;
                  ack0_q  <= ~gnt_q;
                  ack1_q  <= gnt_q;
               end else begin
                  cnt_q <= cnt_q - 17'd1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign div_out = div_q;
   assign busy    = busy_q;
   assign gnt_id  = gnt_q;
   assign ack0    = ack0_q;
   assign ack1    = ack1_q;

endmodule

// File: tb/tb_clkdiv_cfg_ctrl.sv
// Bench for clkdiv_cfg_ctrl: transaction-timeline reference model checked every cycle,
// directed scenarios followed by randomized requester traffic.
module tb_clkdiv_cfg_ctrl;
   localparam int          BYP  = 4;
   localparam int          SET  = 4;
   localparam logic [15:0] DRST = 16'd1;

   logic        clk = 1'b0;
   logic        rst, req0, req1, ack0, ack1, busy, gnt_id;
   logic [15:0] div0, div1, div_out;

   always #5 clk = ~clk;

   clkdiv_cfg_ctrl #(
      .DIV_RST   (DRST),
      .BYP_CYC   (BYP),
      .SETTLE_CYC(SET)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .req0   (req0),
      .div0   (div0),
      .ack0   (ack0),
      .req1   (req1),
      .div1   (div1),
      .ack1   (ack1),
      .div_out(div_out),
      .busy   (busy),
      .gnt_id (gnt_id)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Model: one transaction described by its grant winner, total length and bypass length
   bit          m_busy, m_gnt, m_last;
   int          m_j, m_d, m_byp;
   logic [15:0] m_cur;

   bit          prev_busy = 1'b0;
   int          t_busy = 0;
   bit          seen0, seen1;
   int          lat0, lat1;
   logic        gnt_at_ack;
   bit          dut_gnt_q[$];
   bit          w0, w1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      bit          w;
      logic [15:0] raw, tgt;
      if (rst) begin
         m_busy = 1'b0; m_cur = DRST; m_last = 1'b1; m_gnt = 1'b0;
         m_j = 0; m_d = 0; m_byp = 0;
      end else if (m_busy) begin
         m_j++;
         if (m_j > m_d) m_busy = 1'b0;
      end else if (req0 || req1) begin
         w   = (req0 && req1) ? !m_last : req1;
         raw = w ? div1 : div0;
         tgt = (raw == 16'd0) ? 16'd1 : raw;
         m_last = w; m_gnt = w; m_busy = 1'b1; m_j = 0;
         if (tgt == m_cur) begin
            m_byp = 0; m_d = 0;
         end else if (tgt <= 16'd1 || m_cur <= 16'd1) begin
            m_byp = 0; m_d = SET + int'(tgt);
         end else begin
            m_byp = BYP; m_d = BYP + SET + int'(tgt);
         end
         m_cur = tgt;
      end
   endtask

   task automatic step();
      logic [15:0] e_div;
      bit          e_ack;
      @(posedge clk);
      #1;
      model_edge();
      e_ack = m_busy && (m_j == m_d);
      e_div = (m_busy && m_j < m_byp) ? 16'd1 : m_cur;
      check("div_out", div_out, e_div);
      check("busy", busy, m_busy);
      check("ack0", ack0, e_ack && !m_gnt);
      check("ack1", ack1, e_ack && m_gnt);
      if (m_busy) check("gnt_id", gnt_id, m_gnt);
      if (busy && !prev_busy) begin
         t_busy = 0;
         dut_gnt_q.push_back(gnt_id);
      end else begin
         t_busy++;
      end
      prev_busy = busy;
      if (ack0) begin seen0 = 1'b1; lat0 = t_busy; gnt_at_ack = gnt_id; end
      if (ack1) begin seen1 = 1'b1; lat1 = t_busy; gnt_at_ack = gnt_id; end
      // requesters release right after their acknowledge
      if (e_ack) begin
         if (m_gnt) req1 = 1'b0;
         else       req0 = 1'b0;
      end
   endtask

   task automatic pulse_rst();
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic do_req(input bit id, input logic [15:0] d, input int exp_lat,
                         input logic [15:0] exp_div, input string tag);
      if (id) begin div1 = d; req1 = 1'b1; seen1 = 1'b0; end
      else    begin div0 = d; req0 = 1'b1; seen0 = 1'b0; end
      for (int i = 0; i < exp_lat + 40; i++) begin
         step();
         if (id ? seen1 : seen0) break;
      end
      check({tag, "_acked"}, id ? seen1 : seen0, 1'b1);
      check({tag, "_lat"}, id ? lat1 : lat0, exp_lat);
      check({tag, "_gnt"}, gnt_at_ack, id);
      step();
      check({tag, "_div"}, div_out, exp_div);
   endtask

   function automatic logic [15:0] pick();
      int r;
      r = $urandom_range(0, 5);
      if (r == 0) return 16'd0;
      if (r == 1) return 16'd1;
      if (r == 2) return m_cur;
      return 16'($urandom_range(2, 40));
   endfunction

   initial begin
      bit exp_alt [4];
      exp_alt = '{1'b0, 1'b1, 1'b0, 1'b1};
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; div0 = '0; div1 = '0;
      seen0 = 1'b0; seen1 = 1'b0; lat0 = 0; lat1 = 0; gnt_at_ack = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();
      check("rst_gnt_id", gnt_id, 1'b0);
      check("rst_div", div_out, DRST);

      do_req(1'b0, 16'd8, 12, 16'd8, "first");
      do_req(1'b1, 16'd6, 14, 16'd6, "second");

      // simultaneous requests straight after reset: req0 wins the tie
      pulse_rst();
      dut_gnt_q.delete();
      div0 = 16'd4; div1 = 16'd10; req0 = 1'b1; req1 = 1'b1; seen0 = 1'b0; seen1 = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (seen0 && seen1) break;
      end
      step();
      check("tie_grants", dut_gnt_q.size(), 2);
      if (dut_gnt_q.size() >= 2) begin
         check("tie_first", dut_gnt_q[0], 1'b0);
         check("tie_second", dut_gnt_q[1], 1'b1);
      end
      check("tie_final_div", div_out, 16'd10);

      // both requesters re-request as soon as the protocol allows
      dut_gnt_q.delete();
      div0 = 16'd3; div1 = 16'd7; req0 = 1'b1; req1 = 1'b1; w0 = 1'b0; w1 = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (dut_gnt_q.size() < 4) begin
            if (!req0) begin if (w0) req0 = 1'b1; w0 = 1'b1; end else w0 = 1'b0;
            if (!req1) begin if (w1) req1 = 1'b1; w1 = 1'b1; end else w1 = 1'b0;
         end else if (!req0 && !req1 && !m_busy && !busy) begin
            break;
         end
         step();
      end
      check("alt_grants_ge4", dut_gnt_q.size() >= 4, 1'b1);
      if (dut_gnt_q.size() >= 4)
         for (int k = 0; k < 4; k++) check($sformatf("alt_%0d", k), dut_gnt_q[k], exp_alt[k]);

      do_req(1'b0, 16'd10, 18, 16'd10, "to10");
      do_req(1'b0, 16'd10, 0, 16'd10, "same");
      do_req(1'b1, 16'd1, 5, 16'd1, "to1");
      do_req(1'b1, 16'd0, 0, 16'd1, "zero_at1");
      do_req(1'b0, 16'd5, 9, 16'd5, "to5");
      do_req(1'b1, 16'd0, 5, 16'd1, "zero_at5");

      // reset in the middle of the settle phase of a 5 -> 200 change
      do_req(1'b0, 16'd5, 9, 16'd5, "pre_abort");
      div0 = 16'd200; req0 = 1'b1; seen0 = 1'b0;
      for (int i = 0; i < 9; i++) step();
      check("abort_mid_busy", busy, 1'b1);
      check("abort_mid_div", div_out, 16'd200);
      pulse_rst();
      check("abort_div", div_out, 16'd1);
      check("abort_busy", busy, 1'b0);
      for (int i = 0; i < 250; i++) step();
      check("abort_no_ack", seen0, 1'b0);
      do_req(1'b0, 16'd3, 7, 16'd3, "post_abort");

      do_req(1'b1, 16'hFFFE, 65542, 16'hFFFE, "wide");
      do_req(1'b0, 16'd2, 10, 16'd2, "from_wide");

      w0 = 1'b0; w1 = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            pulse_rst();
            w0 = 1'b0; w1 = 1'b0;
         end
         if (!req0) begin
            if (w0 && $urandom_range(0, 3) == 0) begin div0 = pick(); req0 = 1'b1; end
            w0 = 1'b1;
         end else w0 = 1'b0;
         if (!req1) begin
            if (w1 && $urandom_range(0, 3) == 0) begin div1 = pick(); req1 = 1'b1; end
            w1 = 1'b1;
         end else w1 = 1'b0;
         step();
      end
      for (int i = 0; i < 400; i++) begin
         if (!req0 && !req1 && !m_busy) break;
         step();
      end
      check("drain_idle", busy, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
